// File: rtl/tristate_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tristate_bus_arbiter
//
// This block shares one WIDTH-bit tristate bus among N_CH channels. A
// round-robin arbiter grants one channel at a time. A grant lasts at most
// MAX_BURST cycles. Between two grants the bus floats for TURN cycles. Each
// driven bus value is captured into a register.
//
// Ports
//   clk_in     : clock; all logic runs on the rising edge
//   rst_in     : synchronous reset, active-high
//   req_in     : per-channel request, level-sensitive
//   data_in    : channel k data in bits [k*WIDTH +: WIDTH]
//   grant_out  : registered one-hot grant, or all zero
//   bus_io     : shared bus, driven with the granted channel's data, else 'z
//   y_out      : registered capture of the driven bus
//   valid_out  : high the cycle after a driven bus cycle
//
// Build option
//   TRISTATE_HOLD_LAST_EN : when defined, y_out keeps the last captured value
//                           on undriven cycles (bus-keeper behaviour). When
//                           undefined, y_out clears to zero on those cycles.
// -----------------------------------------------------------------------------
module tristate_bus_arbiter #(
    parameter int WIDTH     = 8,
    parameter int N_CH      = 4,
    parameter int MAX_BURST = 4,
    parameter int TURN      = 1
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic [N_CH-1:0]        req_in,
    input  logic [N_CH*WIDTH-1:0]  data_in,
    output logic [N_CH-1:0]        grant_out,
    inout  wire  [WIDTH-1:0]       bus_io,
    output logic [WIDTH-1:0]       y_out,
    output logic                   valid_out
);

    localparam int PW = $clog2(N_CH);
    localparam int BW = (MAX_BURST < 32'sd1) ? 32'sd1 : $clog2(MAX_BURST + 32'sd1);
    localparam int TW = (TURN < 32'sd1) ? 32'sd1 : $clog2(TURN + 32'sd1);

    localparam logic [BW-1:0]   BURST_MAX = BW'(MAX_BURST);
    localparam logic [BW-1:0]   BURST_ONE = BW'(32'sd1);
    localparam logic [TW-1:0]   TURN_MAX  = TW'(TURN);
    localparam logic [TW-1:0]   TURN_ONE  = TW'(32'sd1);
    localparam logic [PW-1:0]   PTR_RST   = PW'(N_CH - 32'sd1);
    localparam logic [N_CH-1:0] ONE_HOT0  = N_CH'(32'sd1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_TURN  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [N_CH-1:0]   grant_q, grant_d;
    logic [BW-1:0]     burst_q, burst_d;
    logic [TW-1:0]     turn_q, turn_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [WIDTH-1:0]  y_q, y_d;
    logic              valid_q, valid_d;

    logic              arb_found_s;
    logic [PW-1:0]     arb_idx_s;
    logic [PW-1:0]     arb_cand_s;
    logic              launch_s;
    logic [WIDTH-1:0]  bus_drv_s;

    // Round-robin search: the channel after the pointer has top priority, and the pointer itself comes last.
    always_comb begin
        arb_found_s = 1'b0;
        arb_idx_s   = ptr_q;
        arb_cand_s  = ptr_q;
        for (int i = 32'sd1; i <= N_CH; i++) begin
            arb_cand_s  = PW'((int'(ptr_q) + i) % N_CH);
            arb_idx_s   = (req_in[arb_cand_s] && !arb_found_s) ? arb_cand_s : arb_idx_s;
            arb_found_s = arb_found_s | req_in[arb_cand_s];
        end
    end

    // AND-OR mux of the granted channel. Because grant is one-hot or zero, there is never more than one source.
    always_comb begin
        bus_drv_s = '0;
        for (int k = 32'sd0; k < N_CH; k++) begin
            bus_drv_s = bus_drv_s | ({WIDTH{grant_q[k]}} & data_in[k*WIDTH +: WIDTH]);
        end
    end

    assign bus_io = (|grant_q) ? bus_drv_s : {WIDTH{1'bz}};

    // Next-state logic for the grant FSM and its counters.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        burst_d  = burst_q;
        turn_d   = turn_q;
        ptr_d    = ptr_q;
        launch_s = 1'b0;

        case (state_q)
            ST_IDLE: begin
                launch_s = 1'b1;
            end
            ST_DRIVE: begin
                // ptr_q always names the current owner, because it is loaded with the winner on every grant.
                if (!req_in[ptr_q] || (burst_q == BURST_MAX)) begin
                    grant_d = '0;
                    burst_d = '0;
                    if (TURN > 32'sd0) begin
                        state_d = ST_TURN;
                        turn_d  = TURN_ONE;
                    end else begin
                        launch_s = 1'b1;
                    end
                end else begin
                    burst_d = burst_q + BURST_ONE;
                end
            end
            ST_TURN: begin
                if (turn_q < TURN_MAX) begin
                    turn_d = turn_q + TURN_ONE;
                end else begin
                    turn_d   = '0;
                    launch_s = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                burst_d = '0;
                turn_d  = '0;
            end
        endcase

        // Arbitrate at this edge. If a request wins, the next cycle drives the bus; otherwise the FSM parks in IDLE.
        if (launch_s) begin
            if (arb_found_s) begin
                state_d = ST_DRIVE;
                grant_d = ONE_HOT0 << arb_idx_s;
                burst_d = BURST_ONE;
                ptr_d   = arb_idx_s;
            end else begin
                state_d = ST_IDLE;
                grant_d = '0;
                burst_d = '0;
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Capture path. The bus carries bus_drv_s exactly when some channel is granted.
    always_comb begin
        if (|grant_q) begin
            y_d     = bus_drv_s;
            valid_d = 1'b1;
        end else begin
`ifdef TRISTATE_HOLD_LAST_EN
            y_d     = y_q;
`else
            y_d     = '0;
`endif
            valid_d = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            burst_q <= '0;
            turn_q  <= '0;
            ptr_q   <= PTR_RST;
            y_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            burst_q <= burst_d;
            turn_q  <= turn_d;
            ptr_q   <= ptr_d;
            y_q     <= y_d;
            valid_q <= valid_d;
        end
    end

    assign grant_out = grant_q;
    assign y_out     = y_q;
    assign valid_out = valid_q;

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tristate_bus_arbiter
//
// Drives two instances from shared inputs: one with TURN=1 and one with TURN=0.
// A behavioural model tracks, for each instance, the bus owner, its run
// length, the remaining gap cycles, and the round-robin pointer. Every
// cycle, both DUTs are compared against the model. Directed scenarios add
// hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_tristate_bus_arbiter;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int MB = 4;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [3:0]  req_in;
    logic [31:0] data_in;

    logic [3:0]  grant_a, grant_b;
    wire  [7:0]  bus_a, bus_b;
    logic [7:0]  y_a, y_b;
    logic        valid_a, valid_b;

    always #5 clk_in = ~clk_in;

    tristate_bus_arbiter #(.WIDTH(8), .N_CH(4), .MAX_BURST(4), .TURN(1)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .req_in(req_in), .data_in(data_in),
        .grant_out(grant_a), .bus_io(bus_a), .y_out(y_a), .valid_out(valid_a)
    );

    tristate_bus_arbiter #(.WIDTH(8), .N_CH(4), .MAX_BURST(4), .TURN(0)) dut_t0 (
        .clk_in(clk_in), .rst_in(rst_in), .req_in(req_in), .data_in(data_in),
        .grant_out(grant_b), .bus_io(bus_b), .y_out(y_b), .valid_out(valid_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model state per instance: index 0 is TURN=1, index 1 is TURN=0.
    int         m_owner [2];
    int         m_run   [2];
    int         m_gap   [2];
    int         m_ptr   [2];
    int         m_turn  [2];
    logic [7:0] m_y     [2];
    logic       m_valid [2];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge, using the inputs sampled at that edge.
    task automatic model_step(int m);
        bit pick;
        int c;
        if (rst_in) begin
            m_owner[m] = -1;
            m_run[m]   = 0;
            m_gap[m]   = 0;
            m_ptr[m]   = N - 1;
            m_y[m]     = 8'h00;
            m_valid[m] = 1'b0;
        end else begin
            if (m_owner[m] >= 0) begin
                m_y[m]     = data_in[m_owner[m]*W +: W];
                m_valid[m] = 1'b1;
            end else begin
                m_valid[m] = 1'b0;
`ifndef TRISTATE_HOLD_LAST_EN
                m_y[m]     = 8'h00;
`endif
            end
            pick = 1'b0;
            if (m_owner[m] >= 0) begin
                if (!req_in[m_owner[m]] || m_run[m] == MB) begin
                    m_owner[m] = -1;
                    if (m_turn[m] > 0) m_gap[m] = m_turn[m];
                    else pick = 1'b1;
                end else begin
                    m_run[m]++;
                end
            end else if (m_gap[m] > 0) begin
                m_gap[m]--;
                if (m_gap[m] == 0) pick = 1'b1;
            end else begin
                pick = 1'b1;
            end
            if (pick) begin
                for (int i = 1; i <= N; i++) begin
                    c = (m_ptr[m] + i) % N;
                    if (m_owner[m] < 0 && req_in[c]) begin
                        m_owner[m] = c;
                        m_ptr[m]   = c;
                        m_run[m]   = 1;
                    end
                end
            end
        end
    endtask

    task automatic compare(int m, logic [3:0] g, logic [7:0] b, logic [7:0] y, logic v);
        logic [3:0] eg;
        eg = (m_owner[m] >= 0) ? (4'b0001 << m_owner[m]) : 4'b0000;
        check(m == 0 ? "grant_t1" : "grant_t0", {28'd0, g}, {28'd0, eg});
        check(m == 0 ? "valid_t1" : "valid_t0", {31'd0, v}, {31'd0, m_valid[m]});
        check(m == 0 ? "y_t1" : "y_t0", {24'd0, y}, {24'd0, m_y[m]});
        if (m_owner[m] >= 0) begin
            check(m == 0 ? "bus_t1" : "bus_t0", {24'd0, b}, {24'd0, data_in[m_owner[m]*W +: W]});
        end
    endtask

    // Apply the inputs, clock one edge, advance the model, then compare away from the edge.
    task automatic step(logic r, logic [3:0] q, logic [31:0] d);
        rst_in  = r;
        req_in  = q;
        data_in = d;
        @(posedge clk_in);
        model_step(0);
        model_step(1);
        #1;
        compare(0, grant_a, bus_a, y_a, valid_a);
        compare(1, grant_b, bus_b, y_b, valid_b);
    endtask

    task automatic do_reset();
        step(1'b1, 4'b1111, 32'h0);
        step(1'b1, 4'b1111, 32'h0);
    endtask

    initial begin
        logic [3:0] eg;
        m_turn[0] = 1;
        m_turn[1] = 0;
        for (int m = 0; m < 2; m++) begin
            m_owner[m] = -1; m_run[m] = 0; m_gap[m] = 0; m_ptr[m] = N - 1;
            m_y[m] = 8'h00; m_valid[m] = 1'b0;
        end

        // Reset with every channel requesting
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 4'b1111, 32'hFFFF_FFFF);
            check("rst_grant", {28'd0, grant_a}, 32'h0);
            check("rst_y", {24'd0, y_a}, 32'h0);
            check("rst_valid", {31'd0, valid_a}, 32'h0);
        end

        // Single request on ch1: one-cycle grant latency, capture one cycle later
        step(1'b0, 4'b0010, 32'h0000_A500);
        check("single_grant", {28'd0, grant_a}, 32'h2);
        check("single_bus", {24'd0, bus_a}, 32'hA5);
        step(1'b0, 4'b0010, 32'h0000_A500);
        check("single_y", {24'd0, y_a}, 32'hA5);
        check("single_valid", {31'd0, valid_a}, 32'h1);

        // Burst cap with a lone requester: 4 granted cycles, then 1 gap cycle, repeating
        do_reset();
        for (int c = 1; c <= 15; c++) begin
            step(1'b0, 4'b0001, $urandom);
            check("cap_grant", {28'd0, grant_a}, (((c - 1) % 5) < 4) ? 32'h1 : 32'h0);
            if (c >= 2) check("cap_valid", {31'd0, valid_a}, (((c - 2) % 5) < 4) ? 32'h1 : 32'h0);
        end

        // Round-robin with all channels requesting
        do_reset();
        for (int c = 1; c <= 21; c++) begin
            step(1'b0, 4'b1111, $urandom);
            eg = (((c - 1) % 5) < 4) ? (4'b0001 << (((c - 1) / 5) % 4)) : 4'b0000;
            check("rr_grant", {28'd0, grant_a}, {28'd0, eg});
        end

        // Early release of ch2 with ch3 waiting, checked in both TURN builds
        do_reset();
        step(1'b0, 4'b1100, 32'h1122_3344);
        check("early_g1_t1", {28'd0, grant_a}, 32'h4);
        check("early_g1_t0", {28'd0, grant_b}, 32'h4);
        step(1'b0, 4'b1100, 32'h1122_3344);
        check("early_g2_t1", {28'd0, grant_a}, 32'h4);
        step(1'b0, 4'b1000, 32'h1122_3344);
        check("early_gap_t1", {28'd0, grant_a}, 32'h0);
        check("early_next_t0", {28'd0, grant_b}, 32'h8);
        step(1'b0, 4'b1000, 32'h1122_3344);
        check("early_next_t1", {28'd0, grant_a}, 32'h8);

        // Reset during the 3rd drive cycle: the pointer restarts, so ch0 wins next
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 4'b0100, 32'h0077_0000);
        end
        check("mid_grant_pre", {28'd0, grant_a}, 32'h4);
        step(1'b1, 4'b0100, 32'h0077_0000);
        check("mid_grant_rst", {28'd0, grant_a}, 32'h0);
        check("mid_y_rst", {24'd0, y_a}, 32'h0);
        step(1'b0, 4'b1111, 32'h0077_0000);
        check("mid_restart", {28'd0, grant_a}, 32'h1);

        // Value of y on an idle cycle that follows a driven burst
        do_reset();
        step(1'b0, 4'b0010, 32'h0000_5A00);
        step(1'b0, 4'b0010, 32'h0000_5A00);
        step(1'b0, 4'b0000, 32'h0000_5A00);
        check("hold_last_cap", {24'd0, y_a}, 32'h5A);
        step(1'b0, 4'b0000, 32'h0000_5A00);
`ifdef TRISTATE_HOLD_LAST_EN
        check("hold_idle_y", {24'd0, y_a}, 32'h5A);
`else
        check("hold_idle_y", {24'd0, y_a}, 32'h00);
`endif
        check("hold_idle_valid", {31'd0, valid_a}, 32'h0);

        // Randomised traffic with occasional resets
        for (int c = 0; c < 800; c++) begin
            step(($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0,
                 4'($urandom_range(0, 15)), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
